// File: rtl/rv_serdes_interface.sv
// rv_serdes_interface: ready-valid bridge that deserialises bus beats into a device word
// and serialises coherent snapshots of a device word back onto the bus.
module rv_serdes_interface #(
    parameter int BUS_WIDTH  = 8,
    parameter int WORD_BEATS = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                            CLK_I,
    input  logic                            RST_I,
    input  logic                            READ_READY_I,
    output logic                            READ_VALID_O,
    output logic [BUS_WIDTH-1:0]            READ_DATA_O,
    output logic                            WRITE_READY_O,
    input  logic                            WRITE_VALID_I,
    input  logic [BUS_WIDTH-1:0]            WRITE_DATA_I,
    input  logic                            READ_ENABLE_I,
    input  logic                            WRITE_ENABLE_I,
    input  logic                            FLUSH_I,
    output logic                            UPDATE_O,
    output logic [BUS_WIDTH*WORD_BEATS-1:0] DATA_O,
    input  logic                            CHANGE_I,
    input  logic [BUS_WIDTH*WORD_BEATS-1:0] DATA_I,
    output logic                            READ_O
);
    localparam int DATA_WIDTH = BUS_WIDTH * WORD_BEATS;
    localparam int CW = WORD_BEATS > 1 ? $clog2(WORD_BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_BEATS - 1);
    localparam logic W_COLLECT = 1'b0, W_HOLD = 1'b1;
    localparam logic R_IDLE = 1'b0, R_SEND = 1'b1;

    logic                  wstate, rstate, pending;
    logic [CW-1:0]         wbeat, rbeat, wslice, rslice;
    logic [DATA_WIDTH-1:0] snapshot;
    logic                  write_fire, read_fire, capture;

    always_comb begin
        WRITE_READY_O = wstate == W_COLLECT;
        UPDATE_O      = wstate == W_HOLD && WRITE_ENABLE_I && !FLUSH_I;
        write_fire    = WRITE_READY_O && WRITE_VALID_I && !FLUSH_I;
        READ_VALID_O  = rstate == R_SEND && READ_ENABLE_I;
        read_fire     = READ_VALID_O && READ_READY_I && !FLUSH_I;
        READ_O        = read_fire && rbeat == LAST;
        capture       = rstate == R_IDLE && (pending || CHANGE_I || (READ_ENABLE_I && READ_READY_I));
        wslice        = LSB_FIRST ? wbeat : LAST - wbeat;
        rslice        = LSB_FIRST ? rbeat : LAST - rbeat;
        READ_DATA_O   = snapshot[rslice*BUS_WIDTH +: BUS_WIDTH];
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            wstate <= W_COLLECT;
            wbeat  <= '0;
            DATA_O <= '0;
        end else if (FLUSH_I) begin
            wstate <= W_COLLECT;
            wbeat  <= '0;
        end else if (UPDATE_O) begin
            wstate <= W_COLLECT;
        end else if (write_fire) begin
            DATA_O[wslice*BUS_WIDTH +: BUS_WIDTH] <= WRITE_DATA_I;
            wbeat  <= wbeat == LAST ? '0 : wbeat + 1'b1;
            wstate <= wbeat == LAST ? W_HOLD : W_COLLECT;
        end
    end

    // The snapshot is only refreshed from IDLE so a multi-beat read stays coherent;
    // changes seen mid-transfer are remembered and replayed after the last beat.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rstate   <= R_IDLE;
            rbeat    <= '0;
            snapshot <= '0;
            pending  <= 1'b0;
        end else if (FLUSH_I) begin
            rstate  <= R_IDLE;
            rbeat   <= '0;
            pending <= 1'b0;
        end else if (capture) begin
            snapshot <= DATA_I;
            rbeat    <= '0;
            pending  <= 1'b0;
            rstate   <= R_SEND;
        end else begin
            if (CHANGE_I) pending <= 1'b1;
            if (read_fire) begin
                rbeat  <= rbeat == LAST ? '0 : rbeat + 1'b1;
                rstate <= rbeat == LAST ? R_IDLE : R_SEND;
            end
        end
    end
endmodule

// File: tb/tb_rv_serdes_interface.sv
// tb_rv_serdes_interface: scoreboard bench; a word-level model queues expected words and beats,
// a negedge monitor compares every DUT output against the queue heads.
module tb_rv_serdes_interface;
    localparam int BW = 8, WB = 4, DW = 32;

    logic clk = 1'b0, rst = 1'b1;
    logic rready = 0, ren = 0, wvalid = 0, wen = 0, flush = 0, change = 0;
    logic [BW-1:0] wdata = '0;
    logic [DW-1:0] data_i = '0;
    logic rvalid, wready, update, read_o;
    logic [BW-1:0] rdata;
    logic [DW-1:0] data_o;

    rv_serdes_interface #(.BUS_WIDTH(BW), .WORD_BEATS(WB), .LSB_FIRST(1'b1)) dut (
        .CLK_I(clk), .RST_I(rst), .READ_READY_I(rready), .READ_VALID_O(rvalid),
        .READ_DATA_O(rdata), .WRITE_READY_O(wready), .WRITE_VALID_I(wvalid),
        .WRITE_DATA_I(wdata), .READ_ENABLE_I(ren), .WRITE_ENABLE_I(wen), .FLUSH_I(flush),
        .UPDATE_O(update), .DATA_O(data_o), .CHANGE_I(change), .DATA_I(data_i), .READ_O(read_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [BW-1:0] d; logic last; } beat_t;
    beat_t rq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] wacc;
    bit pend;
    int wcnt;
    int compared = 0, mismatched = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: a pending write word blocks further beats until delivered;
    // a captured read word is a list of beats drained one per bus handshake.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rq.delete(); wq.delete(); pend = 0; wcnt = 0; wacc = '0;
        end else if (flush) begin
            rq.delete(); wq.delete(); pend = 0; wcnt = 0;
        end else begin
            if (wq.size() != 0) begin
                if (wen) void'(wq.pop_front());
            end else if (wvalid) begin
                wacc[8*wcnt +: 8] = wdata;
                wcnt++;
                if (wcnt == WB) begin wq.push_back(wacc); wcnt = 0; end
            end
            if (rq.size() == 0) begin
                if (pend || change || (ren && rready)) begin
                    for (int k = 0; k < WB; k++) rq.push_back('{data_i[8*k +: 8], k == WB - 1});
                    pend = 0;
                end
            end else begin
                if (change) pend = 1;
                if (ren && rready) void'(rq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("write_ready", {31'b0, wready}, {31'b0, wq.size() == 0});
            chk("update", {31'b0, update}, {31'b0, wq.size() != 0 && wen && !flush});
            if (update && wq.size() != 0) chk("data_o", data_o, wq[0]);
            chk("read_valid", {31'b0, rvalid}, {31'b0, rq.size() != 0 && ren});
            if (rvalid && rready && !flush && rq.size() != 0) begin
                chk("read_data", {24'b0, rdata}, {24'b0, rq[0].d});
                chk("read_o", {31'b0, read_o}, {31'b0, rq[0].last});
            end else begin
                chk("read_o_idle", {31'b0, read_o}, 32'd0);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wbeat(input logic [BW-1:0] b);
        wvalid = 1; wdata = b; step(); wvalid = 0;
    endtask

    initial begin
        step(2);
        rst = 0;
        chk("reset_data_o", data_o, 32'd0);
        chk("reset_read_data", {24'b0, rdata}, 32'd0);
        chk("reset_write_ready", {31'b0, wready}, 32'd1);
        chk("reset_read_valid", {31'b0, rvalid}, 32'd0);
        step();
        // basic word assembly with device always accepting
        wen = 1;
        wbeat(8'h11); wbeat(8'h22); wbeat(8'h33); wbeat(8'h44);
        step(2);
        // device withholds delivery for five cycles
        wen = 0;
        wbeat(8'h55); wbeat(8'h66); wbeat(8'h77); wbeat(8'h88);
        step(5);
        wen = 1; step();
        wbeat(8'h99); wbeat(8'haa);
        flush = 1; step(); flush = 0;
        wbeat(8'h01); wbeat(8'h02); wbeat(8'h03); wbeat(8'h04);
        step(2);
        // read with consumer backpressure
        ren = 1; data_i = 32'hDEADBEEF; change = 1; step(); change = 0;
        for (int i = 0; i < 12; i++) begin rready = ~rready; step(); end
        rready = 0; flush = 1; step(); flush = 0; step();
        // change arriving mid-transfer is deferred
        rready = 1; data_i = 32'hAABBCCDD; change = 1; step(); change = 0; step();
        data_i = 32'h01020304; change = 1; step(); change = 0;
        step(12);
        ren = 0; flush = 1; step(); flush = 0; step();
        // asynchronous reset in the middle of a read transfer
        ren = 1; rready = 1; data_i = 32'hCAFEF00D; change = 1; step(); change = 0; step();
        @(negedge clk); #2 rst = 1;
        #1;
        chk("async_rst_read_valid", {31'b0, rvalid}, 32'd0);
        chk("async_rst_write_ready", {31'b0, wready}, 32'd1);
        chk("async_rst_data_o", data_o, 32'd0);
        #1 rst = 0;
        step();
        data_i = 32'h13572468; change = 1; step(); change = 0; step(8);
        // randomized traffic on both paths
        for (int i = 0; i < 3000; i++) begin
            wvalid = 1'($urandom % 2);
            wdata  = 8'($urandom);
            wen    = ($urandom % 3) != 0;
            ren    = ($urandom % 4) != 0;
            rready = 1'($urandom % 2);
            change = ($urandom % 8) == 0;
            data_i = $urandom;
            flush  = ($urandom % 50) == 0;
            step();
        end
        wvalid = 0; change = 0; ren = 0; rready = 0; flush = 1; step(); flush = 0; step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rv_serdes_interface.md
Name: rv_serdes_interface

Overview:
- Parametrised successor to the single-register ready-valid bus interface.
- Bridges a narrow ready-valid bus (BUS_WIDTH) to a wide device-side word of WORD_BEATS*BUS_WIDTH bits.
- Write path deserialises bus beats into a word. Read path snapshots the device word and serialises it as beats, with coherent multi-beat transfers and backpressure.
- Sits between the host-facing stream port and trace-buffer control/status registers.

Parameters:
- BUS_WIDTH, 8, bits per bus beat.
- WORD_BEATS, 4, beats per device word (>=1); DATA_WIDTH = BUS_WIDTH*WORD_BEATS is a localparam.
- LSB_FIRST, 1, 1: beat 0 carries bits [BUS_WIDTH-1:0]; 0: beat 0 carries the MSB slice.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  asynchronous, active-high reset.
- READ_READY_I  in  1  bus consumer ready.
- READ_VALID_O  out  1  read beat valid.
- READ_DATA_O  out  BUS_WIDTH  current read beat.
- WRITE_READY_O  out  1  write path can accept a beat.
- WRITE_VALID_I  in  1  write beat valid.
- WRITE_DATA_I  in  BUS_WIDTH  write beat.
- READ_ENABLE_I  in  1  device permits read beats to be presented.
- WRITE_ENABLE_I  in  1  device permits an assembled word to be delivered.
- FLUSH_I  in  1  synchronous discard of partial or pending state on both paths.
- UPDATE_O  out  1  one-cycle strobe: DATA_O holds a new complete word.
- DATA_O  out  DATA_WIDTH  assembled write word.
- CHANGE_I  in  1  device word changed; request a snapshot.
- DATA_I  in  DATA_WIDTH  device word to be read.
- READ_O  out  1  one-cycle strobe: last beat of a word accepted by the bus.

Behaviour:
- Reset, asynchronous on RST_I high:
  - Both FSMs go to their idle states and beat counters clear.
  - DATA_O = 0, the snapshot register = 0 and the change-pending flag = 0.
  - Outputs: READ_VALID_O=0, READ_DATA_O=0, UPDATE_O=0, READ_O=0, WRITE_READY_O=1.
- Handshake: a beat transfers on a rising edge with VALID & READY high. READY never depends combinationally on VALID, in either direction.
- Write FSM, COLLECT -> HOLD -> COLLECT:
  - COLLECT: WRITE_READY_O=1. Each accepted beat writes its slice of DATA_O (slice selected by wbeat and LSB_FIRST) and wbeat increments.
  - Accepting beat WORD_BEATS-1 clears wbeat and moves to HOLD.
  - HOLD: WRITE_READY_O=0. UPDATE_O = WRITE_ENABLE_I, combinational. When UPDATE_O=1 the FSM returns to COLLECT on the next edge.
  - DATA_O stays stable from HOLD entry until the next beat is accepted in COLLECT.
  - WORD_BEATS=1: every accepted beat goes straight to HOLD.
- Read FSM, IDLE -> SEND -> IDLE:
  - IDLE: READ_VALID_O=0. If CHANGE_I=1, or READ_ENABLE_I & READ_READY_I = 1 (bus poll), capture DATA_I into the snapshot, set rbeat=0 and go to SEND.
  - SEND: READ_VALID_O = READ_ENABLE_I. READ_DATA_O = snapshot slice[rbeat], ordered per LSB_FIRST. Each handshake increments rbeat.
  - Handshake on beat WORD_BEATS-1: READ_O=1 in that same cycle, combinational; rbeat clears; FSM returns to IDLE.
  - CHANGE_I while in SEND does not alter the snapshot (coherency); it sets change-pending instead.
  - On return to IDLE with change-pending set, re-capture DATA_I on the next edge, clear the flag and re-enter SEND, giving one idle cycle.
  - READ_ENABLE_I low in SEND stalls without losing rbeat.
- FLUSH_I, synchronous, higher priority than any same-cycle handshake:
  - Write FSM -> COLLECT with wbeat=0; DATA_O is retained.
  - Read FSM -> IDLE with rbeat=0; change-pending cleared.
  - No UPDATE_O or READ_O in that cycle.
- Simultaneous events:
  - Bus write beat and device read transfer are independent.
  - CHANGE_I on the same edge as the final read handshake sets change-pending.
- Counters: width = max(1, $clog2(WORD_BEATS)); never exceed WORD_BEATS-1.
- Reset asserted mid-word discards all partial state immediately (asynchronous).

Test Plan:
- Write 4 beats 0x11,0x22,0x33,0x44 with WRITE_ENABLE_I=1, LSB_FIRST=1 -> DATA_O=0x44332211; UPDATE_O high for exactly 1 cycle; WRITE_READY_O low in HOLD.
- WRITE_ENABLE_I=0 for 5 cycles after the 4th beat -> WRITE_READY_O=0 and UPDATE_O=0 throughout; raising enable gives a 1-cycle UPDATE_O, then a further beat is accepted.
- CHANGE_I with DATA_I=0xDEADBEEF, READ_READY_I toggling -> beats 0xEF,0xBE,0xAD,0xDE in order; READ_O only on the 0xDE handshake.
- CHANGE_I with DATA_I=0x01020304 during beat 1 of a 0xAABBCCDD transfer -> full 0xDD,0xCC,0xBB,0xAA, then after 1 idle cycle 0x04,0x03,0x02,0x01.
- FLUSH_I after 2 write beats, then 4 beats 0x01..0x04 -> DATA_O=0x04030201; a single UPDATE_O strobe, occurring after the 4th new beat.
- RST_I pulsed asynchronously mid-read (between edges) -> READ_VALID_O=0 and WRITE_READY_O=1 before the next edge; the next CHANGE_I restarts at beat 0.
